// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline register with valid/ready
// handshake on both sides, a legacy hold (stall) input and a flush input.
// SKID=1 adds a 2-entry skid buffer so in_ready comes straight from a flop.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
`else
    output logic [DATA_W-1:0] out_data
`endif
);

    logic              head_v_r;
    logic [DATA_W-1:0] head_d_r;
    logic              skid_v_r;
    logic [DATA_W-1:0] skid_d_r;
    logic              head_v_nx_s;
    logic [DATA_W-1:0] head_d_nx_s;
    logic              skid_v_nx_s;
    logic [DATA_W-1:0] skid_d_nx_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // With SKID=0 the skid entry is never loaded: in_ready only rises while the
    // head is empty or leaving, so the shared state machine never reaches FULL.
    assign in_ready_s = (SKID != 0) ? ~skid_v_r : (~head_v_r | (out_ready & ~hold));
    assign in_fire_s  = in_valid & in_ready_s;
    assign out_fire_s = head_v_r & out_ready & ~hold;

    assign in_ready  = in_ready_s;
    assign out_valid = head_v_r;
    assign out_data  = head_d_r;

    // Next-state logic for the {head_v, skid_v} state machine, flush first.
    always_comb begin
        head_v_nx_s = head_v_r;
        head_d_nx_s = head_d_r;
        skid_v_nx_s = skid_v_r;
        skid_d_nx_s = skid_d_r;
        if (flush) begin
            head_v_nx_s = 1'b0;
            head_d_nx_s = {DATA_W{1'b0}};
            skid_v_nx_s = 1'b0;
            skid_d_nx_s = {DATA_W{1'b0}};
        end else begin
            case ({head_v_r, skid_v_r})
                2'b00: begin
                    if (in_fire_s) begin
                        head_v_nx_s = 1'b1;
                        head_d_nx_s = in_data;
                    end else begin
                        head_v_nx_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (in_fire_s && out_fire_s) begin
                        head_d_nx_s = in_data;
                    end else if (in_fire_s) begin
                        skid_v_nx_s = 1'b1;
                        skid_d_nx_s = in_data;
                    end else if (out_fire_s) begin
                        head_v_nx_s = 1'b0;
                    end else begin
                        head_v_nx_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_fire_s) begin
                        head_d_nx_s = skid_d_r;
                        skid_v_nx_s = 1'b0;
                    end else begin
                        skid_v_nx_s = 1'b1;
                    end
                end
                default: begin
                    head_v_nx_s = head_v_r;
                    skid_v_nx_s = skid_v_r;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v_r <= 1'b0;
            head_d_r <= {DATA_W{1'b0}};
            skid_v_r <= 1'b0;
            skid_d_r <= {DATA_W{1'b0}};
        end else begin
            head_v_r <= head_v_nx_s;
            head_d_r <= head_d_nx_s;
            skid_v_r <= skid_v_nx_s;
            skid_d_r <= skid_d_nx_s;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] stall_cnt_nx_s;
    logic [CNT_W-1:0] bubble_cnt_nx_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Counter increments; flush does not clear them, only rst does.
    always_comb begin
        stall_cnt_nx_s  = stall_cnt_r;
        bubble_cnt_nx_s = bubble_cnt_r;
        if (head_v_r && !(out_ready && !hold)) begin
            stall_cnt_nx_s = sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_nx_s = stall_cnt_r;
        end
        if (!head_v_r) begin
            bubble_cnt_nx_s = sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_nx_s = bubble_cnt_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r  <= stall_cnt_nx_s;
            bubble_cnt_r <= bubble_cnt_nx_s;
        end
    end

    assign perf_stall_cnt  = stall_cnt_r;
    assign perf_bubble_cnt = bubble_cnt_r;
`endif

    pipe_stage_buf_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .head_v (head_v_r),
        .skid_v (skid_v_r)
    );

endmodule

// pipe_stage_buf_chk: flags the unreachable state (head empty, skid full).
module pipe_stage_buf_chk (
    input logic clk,
    input logic rst,
    input logic head_v,
    input logic skid_v
);

    a_no_skid_without_head: assert property (
        @(posedge clk) disable iff (rst) !(!head_v && skid_v)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed-vector bench for pipe_stage_buf.
// Instance a uses SKID=1, instance b uses SKID=0; both DATA_W=8.
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_flush, a_hold, a_in_valid, a_out_ready;
    logic [7:0] a_in_data;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic       b_flush, b_hold, b_in_valid, b_out_ready;
    logic [7:0] b_in_data;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0] a_stall, a_bubble;
    logic [3:0] b_stall, b_bubble;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(8), .SKID(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .hold(a_hold),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(a_out_data), .perf_stall_cnt(a_stall), .perf_bubble_cnt(a_bubble)
`else
        .out_data(a_out_data)
`endif
    );

    pipe_stage_buf #(.DATA_W(8), .SKID(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .hold(b_hold),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data(b_out_data), .perf_stall_cnt(b_stall), .perf_bubble_cnt(b_bubble)
`else
        .out_data(b_out_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_hold = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 8'h00;
        b_flush = 1'b0; b_hold = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'h00;
        tick(); tick();
        check("rst_a_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_data", {24'd0, a_out_data}, 32'd0);
        check("rst_a_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        rst = 1'b0;

        // Stream 1,2,3 with downstream always ready.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(i);
            tick();
            check("stream_valid", {31'd0, a_out_valid}, 32'd1);
            check("stream_data", {24'd0, a_out_data}, 32'(i));
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drained", {31'd0, a_out_valid}, 32'd0);

        // Backpressure fills head and skid; drain must keep order.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h0A;
        tick();
        check("bp_ready_after_a", {31'd0, a_in_ready}, 32'd1);
        a_in_data = 8'h0B;
        tick();
        check("bp_ready_full", {31'd0, a_in_ready}, 32'd0);
        a_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_hold_valid", {31'd0, a_out_valid}, 32'd1);
        check("bp_hold_data", {24'd0, a_out_data}, 32'h0A);
        a_out_ready = 1'b1;
        #1;
        check("bp_ready_registered", {31'd0, a_in_ready}, 32'd0);
        tick();
        check("bp_second_data", {24'd0, a_out_data}, 32'h0B);
        check("bp_ready_rise", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("bp_empty", {31'd0, a_out_valid}, 32'd0);

        // Hold freezes a valid head.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h55;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", {31'd0, a_out_valid}, 32'd1);
            check("hold_data", {24'd0, a_out_data}, 32'h55);
        end
        a_hold = 1'b0;
        tick();
        check("hold_release", {31'd0, a_out_valid}, 32'd0);

        // Flush while FULL drops 0x77.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11;
        tick();
        a_in_data = 8'h22;
        tick();
        a_in_data = 8'h77; a_flush = 1'b1;
        tick();
        check("flush_full_valid", {31'd0, a_out_valid}, 32'd0);
        check("flush_full_data", {24'd0, a_out_data}, 32'd0);
        check("flush_full_ready", {31'd0, a_in_ready}, 32'd1);
        // Flush in HEAD state with in_ready=1 still drops the input.
        a_flush = 1'b0; a_in_data = 8'h33;
        tick();
        a_flush = 1'b1; a_hold = 1'b1; a_in_data = 8'h77;
        #1;
        check("flush_head_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("flush_head_valid", {31'd0, a_out_valid}, 32'd0);
        a_flush = 1'b0; a_hold = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        check("flush_no_77", {31'd0, a_out_valid}, 32'd0);

        // SKID=0: combinational ready and simultaneous replace.
        b_in_valid = 1'b1; b_in_data = 8'h10;
        #1;
        check("s0_ready_empty", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("s0_head", {24'd0, b_out_data}, 32'h10);
        b_in_data = 8'h20;
        #1;
        check("s0_ready_blocked", {31'd0, b_in_ready}, 32'd0);
        b_out_ready = 1'b1; b_hold = 1'b1;
        #1;
        check("s0_ready_hold", {31'd0, b_in_ready}, 32'd0);
        b_hold = 1'b0;
        #1;
        check("s0_ready_same_cycle", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("s0_replace_data", {24'd0, b_out_data}, 32'h20);
        check("s0_replace_valid", {31'd0, b_out_valid}, 32'd1);
        b_in_valid = 1'b0;
        tick();
        check("s0_drain", {31'd0, b_out_valid}, 32'd0);
        check("s0_data_kept", {24'd0, b_out_data}, 32'h20);

`ifdef PIPE_STAGE_PERF_EN
        // Performance counters: saturation, survive flush, cleared by rst.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_rst_stall", {28'd0, a_stall}, 32'd0);
        check("perf_rst_bubble", {28'd0, a_bubble}, 32'd0);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h42;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("perf_stall_sat", {28'd0, a_stall}, 32'd15);
        check("perf_bubble_1", {28'd0, a_bubble}, 32'd1);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("perf_flush_keep", {28'd0, a_stall}, 32'd15);
        tick();
        check("perf_bubble_2", {28'd0, a_bubble}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_clear_stall", {28'd0, a_stall}, 32'd0);
        check("perf_clear_bubble", {28'd0, a_bubble}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed-field stage registers that have a flush input and a write enable.
- Carries an opaque DATA_W payload with a valid/ready handshake on both sides, plus a legacy hold (stall) input and a flush input.
- Optionally adds a 2-entry skid buffer so that in_ready is fully registered, which breaks the ready path between stages (for example MEM to MEM2).

Parameters:
- DATA_W, 128, payload width in bits (>=1).
- SKID, 1: 0 = single register with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.
- CNT_W, 32, width of the performance counters (used only with PIPE_STAGE_PERF_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill all held entries; active-high.
- hold  in  1  stall: blocks the output transfer (equivalent to a write enable of 0 downstream).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- perf_stall_cnt  out  CNT_W  cycles with a valid head not transferred (PIPE_STAGE_PERF_EN only).
- perf_bubble_cnt  out  CNT_W  cycles with out_valid=0 (PIPE_STAGE_PERF_EN only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Priority: rst > flush > normal operation, evaluated at each rising edge.
- Reset: out_valid=0, out_data=0, skid entry invalid with data 0, counters=0. Inputs are ignored while rst=1.
- Flush: next cycle out_valid=0, out_data=0, skid cleared.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - Flush overrides hold.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~hold.
- Latency is 1 cycle: a payload accepted at edge N appears on out_data after edge N.
- Ordering is strict FIFO. There is no duplication and no loss, except on flush.
- SKID=0:
  - in_ready = ~out_valid | (out_ready & ~hold). This is combinational.
  - in_fire loads the head register.
  - An out_fire without an in_fire clears out_valid. out_data holds its last value.
  - Simultaneous in_fire and out_fire: the head is replaced and out_valid stays 1.
- SKID=1, state machine on {head_v, skid_v}:
  - in_ready = ~skid_v. This is registered and does not depend on out_ready or hold in the same cycle.
  - EMPTY (0,0):
    - in_fire -> HEAD.
  - HEAD (1,0):
    - in_fire & out_fire: head <= in, stay in HEAD.
    - in_fire & ~out_fire: skid <= in -> FULL.
    - out_fire only -> EMPTY.
  - FULL (1,1): in_ready=0.
    - out_fire: head <= skid -> HEAD.
    - Otherwise hold all state.
  - (0,1) is unreachable. An assertion must flag it.
- In the FULL state, one cycle after out_fire in_ready rises to 1. Back-to-back streaming with out_ready=1 and hold=0 sustains 1 transfer per cycle.
- out_data is stable while out_valid=1 and no out_fire occurs.
- Wrap-around and corner cases:
  - A hold asserted indefinitely keeps the contents intact.
  - Releasing hold resumes transfers with no bubble.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: perf_stall_cnt and perf_bubble_cnt exist.
  - perf_stall_cnt increments on every cycle with out_valid & ~(out_ready & ~hold).
  - perf_bubble_cnt increments on every cycle with ~out_valid.
  - Both are cleared only by rst, are not cleared by flush, and saturate at 2^CNT_W-1.
- Undefined: the ports and their logic are absent. Handshake behaviour is identical.

Test Plan:
- Reset then stream: rst 2 cycles, then in_data=0x1,0x2,0x3 on consecutive cycles with out_ready=1, hold=0 -> out_data 0x1,0x2,0x3 on the 3 following cycles; out_valid=1 for exactly 3 cycles.
- Backpressure, SKID=1: feed 0xA, 0xB with out_ready=0 -> in_ready=0 after the second accept; hold 5 cycles; raise out_ready -> 0xA then 0xB, in order; in_ready=1 one cycle after the first out_fire.
- Hold: state HEAD=0x55, out_ready=1, hold=1 for 4 cycles -> out_valid=1 and out_data=0x55 stable, no transfer; hold=0 -> single transfer of 0x55.
- Flush while FULL with in_valid=1 and in_data=0x77 -> next cycle out_valid=0, out_data=0, in_ready=1; 0x77 never appears.
- SKID=0 simultaneous: head=0x10, out_ready=1, in_valid=1, in_data=0x20 -> in_ready=1 in the same cycle; next cycle out_data=0x20 and out_valid=1.
- PIPE_STAGE_PERF_EN, CNT_W=4: 20 cycles with head valid and out_ready=0 -> perf_stall_cnt saturates at 15; flush -> counts retained; rst -> 0.
